cache_stats_tracker: RTL and testbench



---
 rtl/cache_stats_pkg.sv | 29 ++
 rtl/stat_counter.sv | 41 ++++
 rtl/cache_stats_tracker.sv | 139 +++++++++++++
 tb/tb_cache_stats_tracker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared definitions for the cache statistics tracker: FSM encoding, default widths,
// error-flag bit positions and statistics counter indices.
package cache_stats_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefCntW = 32;
    localparam int unsigned DefOutW = 4;

    localparam int unsigned ErrUnderflow = 0;
    localparam int unsigned ErrOverflow  = 1;
    localparam int unsigned ErrMismatch  = 2;

    localparam int unsigned NumCnt    = 8;
    localparam int unsigned IdxAcc    = 0;
    localparam int unsigned IdxHit    = 1;
    localparam int unsigned IdxMiss   = 2;
    localparam int unsigned IdxRdHit  = 3;
    localparam int unsigned IdxWrHit  = 4;
    localparam int unsigned IdxRdMiss = 5;
    localparam int unsigned IdxWrMiss = 6;
    localparam int unsigned IdxEvict  = 7;

endpackage

// File: rtl/stat_counter.sv
// Single statistics counter with synchronous clear; saturates at all-ones when SAT=1,
// otherwise wraps.
module stat_counter
    import cache_stats_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (SAT && (&cnt_q)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_stats_tracker.sv
// Collects per-access cache results into eight totals, tracks requests still awaiting a
// result, and signals completion once end-of-trace is seen and all requests have drained.
module cache_stats_tracker
    import cache_stats_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW,
    parameter bit          SAT   = 1'b1,
    parameter int unsigned OUT_W = DefOutW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             req_valid,
    input  logic             res_valid,
    input  logic             res_write,
    input  logic             res_hit,
    input  logic             res_evict,
    input  logic             end_file,
    input  logic [31:0]      inst_total,
    output logic [CNT_W-1:0] accessesTotal,
    output logic [CNT_W-1:0] hitTotal,
    output logic [CNT_W-1:0] missTotal,
    output logic [CNT_W-1:0] readHitTotal,
    output logic [CNT_W-1:0] writeHitTotal,
    output logic [CNT_W-1:0] readMissTotal,
    output logic [CNT_W-1:0] writeMissTotal,
    output logic [CNT_W-1:0] evictionTotal,
    output logic [OUT_W-1:0] outstanding,
    output logic             busy,
    output logic             stats_done,
    output logic [2:0]       err_flags
);

    state_e           state_d, state_q;
    logic [OUT_W-1:0] out_d, out_q;
    logic [2:0]       err_d, err_q;
    logic             active, req_ev, res_ev;
    logic [NumCnt-1:0] inc;
    logic [CNT_W-1:0] cnt [NumCnt];
    logic [CNT_W-1:0] acc_final;

    assign active = (state_q == StRun) || (state_q == StDrain);
    assign req_ev = active && req_valid;
    assign res_ev = active && res_valid;

    always_comb begin
        inc            = '0;
        inc[IdxAcc]    = res_ev;
        inc[IdxHit]    = res_ev && res_hit;
        inc[IdxMiss]   = res_ev && !res_hit;
        inc[IdxRdHit]  = res_ev && !res_write && res_hit;
        inc[IdxWrHit]  = res_ev && res_write && res_hit;
        inc[IdxRdMiss] = res_ev && !res_write && !res_hit;
        inc[IdxWrMiss] = res_ev && res_write && !res_hit;
        inc[IdxEvict]  = res_ev && !res_hit && res_evict;
    end

    for (genvar g = 0; g < NumCnt; g++) begin : g_cnt
        stat_counter #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cnt (
            .clk   (clk),
            .rstn  (rstn),
            .clr_i (start),
            .inc_i (inc[g]),
            .cnt_o (cnt[g])
        );
    end

    // Accesses total as it will read after this cycle's update, for the DONE-entry compare.
    always_comb begin
        acc_final = cnt[IdxAcc];
        if (res_ev && !(SAT && (&cnt[IdxAcc]))) begin
            acc_final = cnt[IdxAcc] + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        err_d   = err_q;
        if (start) begin
            state_d = StRun;
            out_d   = '0;
            err_d   = '0;
        end else begin
            unique case ({req_ev, res_ev})
                2'b10: begin
                    if (&out_q) err_d[ErrOverflow] = 1'b1;
                    else        out_d = out_q + OUT_W'(1);
                end
                2'b01: begin
                    if (out_q == '0) err_d[ErrUnderflow] = 1'b1;
                    else             out_d = out_q - OUT_W'(1);
                end
                default: ;
            endcase
            case (state_q)
                StIdle:  ;
                StRun:   if (end_file) state_d = StDrain;
                StDrain: begin
                    if (out_d == '0) begin
                        state_d = StDone;
                        if (acc_final != CNT_W'(inst_total)) err_d[ErrMismatch] = 1'b1;
                    end
                end
                StDone:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            out_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign accessesTotal  = cnt[IdxAcc];
    assign hitTotal       = cnt[IdxHit];
    assign missTotal      = cnt[IdxMiss];
    assign readHitTotal   = cnt[IdxRdHit];
    assign writeHitTotal  = cnt[IdxWrHit];
    assign readMissTotal  = cnt[IdxRdMiss];
    assign writeMissTotal = cnt[IdxWrMiss];
    assign evictionTotal  = cnt[IdxEvict];
    assign outstanding    = out_q;
    assign busy           = active;
    assign stats_done     = (state_q == StDone);
    assign err_flags      = err_q;

endmodule

// File: tb/tb_cache_stats_tracker.sv
// Directed bench for cache_stats_tracker: a vector table for the main flow plus
// hand-written sequences for overflow, reset mid-drain and counter limits.
module tb_cache_stats_tracker;

    logic        clk = 1'b0;
    logic        rstn, start, req_valid, res_valid, res_write, res_hit, res_evict, end_file;
    logic [31:0] inst_total;
    logic [31:0] acc_o, hit_o, miss_o, rh_o, wh_o, rm_o, wm_o, ev_o;
    logic [3:0]  out_o;
    logic        busy_o, done_o;
    logic [2:0]  err_o;

    logic       s_start, s_req, s_res, s_hit;
    logic [3:0] sat_c [8];
    logic [3:0] wrp_c [8];
    logic [3:0] sat_out, wrp_out;
    logic       sat_busy, wrp_busy, sat_done, wrp_done;
    logic [2:0] sat_err, wrp_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_stats_tracker u_dut (
        .clk(clk), .rstn(rstn), .start(start), .req_valid(req_valid), .res_valid(res_valid),
        .res_write(res_write), .res_hit(res_hit), .res_evict(res_evict), .end_file(end_file),
        .inst_total(inst_total), .accessesTotal(acc_o), .hitTotal(hit_o), .missTotal(miss_o),
        .readHitTotal(rh_o), .writeHitTotal(wh_o), .readMissTotal(rm_o),
        .writeMissTotal(wm_o), .evictionTotal(ev_o), .outstanding(out_o), .busy(busy_o),
        .stats_done(done_o), .err_flags(err_o)
    );

    cache_stats_tracker #(.CNT_W(4), .SAT(1'b1), .OUT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .start(s_start), .req_valid(s_req), .res_valid(s_res),
        .res_write(1'b0), .res_hit(s_hit), .res_evict(1'b0), .end_file(1'b0),
        .inst_total(32'd0), .accessesTotal(sat_c[0]), .hitTotal(sat_c[1]),
        .missTotal(sat_c[2]), .readHitTotal(sat_c[3]), .writeHitTotal(sat_c[4]),
        .readMissTotal(sat_c[5]), .writeMissTotal(sat_c[6]), .evictionTotal(sat_c[7]),
        .outstanding(sat_out), .busy(sat_busy), .stats_done(sat_done), .err_flags(sat_err)
    );

    cache_stats_tracker #(.CNT_W(4), .SAT(1'b0), .OUT_W(4)) u_wrp (
        .clk(clk), .rstn(rstn), .start(s_start), .req_valid(s_req), .res_valid(s_res),
        .res_write(1'b0), .res_hit(s_hit), .res_evict(1'b0), .end_file(1'b0),
        .inst_total(32'd0), .accessesTotal(wrp_c[0]), .hitTotal(wrp_c[1]),
        .missTotal(wrp_c[2]), .readHitTotal(wrp_c[3]), .writeHitTotal(wrp_c[4]),
        .readMissTotal(wrp_c[5]), .writeMissTotal(wrp_c[6]), .evictionTotal(wrp_c[7]),
        .outstanding(wrp_out), .busy(wrp_busy), .stats_done(wrp_done), .err_flags(wrp_err)
    );

    typedef struct {
        logic        st, rq, rs, wr, ht, ev, ef;
        logic [31:0] inst;
        logic [3:0]  out;
        int          acc, hit, miss, rh, wh, rm, wm, evt;
        logic        busy, done;
        logic [2:0]  err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, rq, rs, wr, ht, ev, ef, input int inst,
                                input int out, acc, hit, miss, rh, wh, rm, wm, evt,
                                input logic busy, done, input logic [2:0] err);
        vec_t v;
        v.st = st; v.rq = rq; v.rs = rs; v.wr = wr; v.ht = ht; v.ev = ev; v.ef = ef;
        v.inst = inst; v.out = 4'(out); v.acc = acc; v.hit = hit; v.miss = miss;
        v.rh = rh; v.wh = wh; v.rm = rm; v.wm = wm; v.evt = evt;
        v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int out, acc, hit, miss, rh, wh, rm,
                             wm, evt, input logic busy, done, input logic [2:0] err);
        chk({tag, " outstanding"}, 32'(out_o), out);
        chk({tag, " accesses"}, acc_o, acc);
        chk({tag, " hit"}, hit_o, hit);
        chk({tag, " miss"}, miss_o, miss);
        chk({tag, " readHit"}, rh_o, rh);
        chk({tag, " writeHit"}, wh_o, wh);
        chk({tag, " readMiss"}, rm_o, rm);
        chk({tag, " writeMiss"}, wm_o, wm);
        chk({tag, " eviction"}, ev_o, evt);
        chk({tag, " busy"}, 32'(busy_o), 32'(busy));
        chk({tag, " stats_done"}, 32'(done_o), 32'(done));
        chk({tag, " err_flags"}, 32'(err_o), 32'(err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        start = 0; req_valid = 0; res_valid = 0; end_file = 0;
    endtask

    initial begin
        rstn = 0; clear_pulses(); res_write = 0; res_hit = 0; res_evict = 0;
        inst_total = 0; s_start = 0; s_req = 0; s_res = 0; s_hit = 0;
        step(); step();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        rstn = 1;
        start = 1; step(); clear_pulses();
        check_all("start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);

        //                st rq rs wr ht ev ef inst out acc hit mis rh wh rm wm ev bsy dn err
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4, 3, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4, 2, 2, 1, 1, 1, 0, 1, 0, 1, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4, 1, 3, 2, 1, 1, 1, 1, 0, 1, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4, 0, 4, 2, 2, 1, 1, 1, 1, 1, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 4, 2, 2, 1, 1, 1, 1, 1, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 4, 2, 2, 1, 1, 1, 1, 1, 0, 1, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 4, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 4, 1, 2, 1, 1, 1, 0, 1, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 2, 2, 1, 1, 1, 0, 1, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4, 3, 2, 1, 1, 1, 0, 1, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 3, 2, 1, 1, 1, 0, 1, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4, 2, 3, 2, 1, 1, 1, 1, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4, 1, 4, 3, 1, 1, 2, 1, 0, 0, 1, 0, 3'b001));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 5, 0, 5, 3, 2, 1, 2, 1, 1, 1, 0, 1, 3'b001));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5, 0, 5, 3, 2, 1, 2, 1, 1, 1, 0, 1, 3'b001));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 5, 3, 2, 1, 2, 1, 1, 1, 0, 1, 3'b001));

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; req_valid = vecs[i].rq; res_valid = vecs[i].rs;
            res_write = vecs[i].wr; res_hit = vecs[i].ht; res_evict = vecs[i].ev;
            end_file = vecs[i].ef; inst_total = vecs[i].inst;
            step();
            clear_pulses();
            check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].acc, vecs[i].hit,
                      vecs[i].miss, vecs[i].rh, vecs[i].wh, vecs[i].rm, vecs[i].wm,
                      vecs[i].evt, vecs[i].busy, vecs[i].done, vecs[i].err);
        end

        // Outstanding counter overflow at all-ones.
        start = 1; step(); clear_pulses();
        for (int i = 0; i < 15; i++) begin
            req_valid = 1; step();
        end
        req_valid = 0;
        check_all("ovf15", 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        req_valid = 1; step(); req_valid = 0;
        check_all("ovf16", 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b010);

        // Reset in DRAIN, then ignored events, then count mismatch.
        end_file = 1; step(); end_file = 0;
        check_all("drain", 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b010);
        rstn = 0; step(); rstn = 1;
        check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        req_valid = 1; step(); req_valid = 0;
        res_valid = 1; res_hit = 1; res_write = 0; res_evict = 0; step(); res_valid = 0;
        end_file = 1; step(); end_file = 0;
        check_all("idle_ign", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        start = 1; step(); clear_pulses();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; step();
        end
        req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            res_valid = 1; step();
        end
        res_valid = 0;
        inst_total = 5;
        end_file = 1; step(); end_file = 0;
        check_all("mm_drain", 0, 4, 4, 0, 4, 0, 0, 0, 0, 1, 0, 3'b000);
        step();
        check_all("mm_done", 0, 4, 4, 0, 4, 0, 0, 0, 0, 0, 1, 3'b100);

        // Counter limits on 4-bit instances: 14 hits, then 3 more.
        s_start = 1; step(); s_start = 0;
        s_req = 1; s_res = 1; s_hit = 1;
        for (int i = 0; i < 14; i++) step();
        chk("sat hit14", 32'(sat_c[1]), 32'd14);
        chk("wrp hit14", 32'(wrp_c[1]), 32'd14);
        for (int i = 0; i < 3; i++) step();
        s_req = 0; s_res = 0; s_hit = 0;
        chk("sat hit", 32'(sat_c[1]), 32'd15);
        chk("sat acc", 32'(sat_c[0]), 32'd15);
        chk("wrp hit", 32'(wrp_c[1]), 32'd1);
        chk("wrp acc", 32'(wrp_c[0]), 32'd1);
        chk("sat outstanding", 32'(sat_out), 32'd0);
        chk("sat err", 32'(sat_err), 32'd0);
        chk("wrp busy", 32'(wrp_busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
